// File: rtl/wbu_pipeline_pkg.sv
// Shared writeback-stage definitions: CSR addresses, trap cause, FSM states.
// Imported by wbu_csr_file and wbu_pipeline.
package wbu_pipeline_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRH  = 12'hB82;

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } wbu_state_e;

endpackage

// File: rtl/wbu_csr_file.sv
// Machine CSRs (mstatus, mtvec, mepc, mcause) with write decode and a
// combinational read mux. Ports: clk/rst, wen/waddr/wdata write, trap/trap_pc
// ecall capture, retire count strobe, raddr/rdata read, mtvec/mepc taps.
// WBU_INSTRET_EN adds a 64-bit minstret readable at 0xB02/0xB82.
module wbu_csr_file
    import wbu_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
    parameter logic [31:0] ECALL_CAUSE   = CAUSE_ECALL_M
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic [11:0] waddr,
    input  logic [31:0] wdata,
    input  logic        trap,
    input  logic [31:0] trap_pc,
    input  logic        retire,
    input  logic [11:0] raddr,
    output logic [31:0] rdata,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic [31:0] mstatus;
    logic [31:0] mcause;

    // Trap capture and software writes are mutually exclusive upstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus <= RESET_MSTATUS;
            mtvec   <= RESET_MTVEC;
            mepc    <= 32'd0;
            mcause  <= 32'd0;
        end else if (trap) begin
            mepc    <= trap_pc;
            mcause  <= ECALL_CAUSE;
        end else if (wen) begin
            case (waddr)
                CSR_MSTATUS: mstatus <= wdata;
                CSR_MTVEC:   mtvec   <= wdata;
                CSR_MEPC:    mepc    <= wdata;
                CSR_MCAUSE:  mcause  <= wdata;
                default: ;
            endcase
        end
    end

`ifdef WBU_INSTRET_EN
    logic [63:0] minstret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minstret <= 64'd0;
        end else if (retire) begin
            minstret <= minstret + 64'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    always_comb begin
        rdata = 32'd0;
        unique case (1'b1)
            (raddr == CSR_MSTATUS):  rdata = mstatus;
            (raddr == CSR_MTVEC):    rdata = mtvec;
            (raddr == CSR_MEPC):     rdata = mepc;
            (raddr == CSR_MCAUSE):   rdata = mcause;
`ifdef WBU_INSTRET_EN
            (raddr == CSR_MINSTRET): rdata = minstret[31:0];
            (raddr == CSR_MINSTRH):  rdata = minstret[63:32];
`endif
            default:                 rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/wbu_pipeline.sv
// Writeback stage: retires one instruction per valid/ready handshake, writes
// the register file, owns the machine CSRs and handles ecall/mret/ebreak.
// Ports: in_* upstream bundle, rf_* regfile write, csr_raddr/csr_rdata read
// port, redirect_*/flush trap control, halt, retire_valid/retire_pc.
// Optional: define WBU_INSTRET_EN to add the minstret counter.
module wbu_pipeline
    import wbu_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
    parameter logic [31:0] ECALL_CAUSE   = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_result,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_wen,
    input  logic        in_csr_wen,
    input  logic [11:0] in_csr_addr,
    input  logic [31:0] in_csr_wdata,
    input  logic        in_ebreak,
    input  logic        in_ecall,
    input  logic        in_mret,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        halt,
    output logic        retire_valid,
    output logic [31:0] retire_pc
);

    wbu_state_e state_q;
    wbu_state_e state_d;

    logic        accept;
    logic        do_ebreak;
    logic        do_ecall;
    logic        do_mret;
    logic        csr_wen;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        unused_inst;

    assign unused_inst = ^in_inst;

    // Precedence ebreak > ecall > mret; any of them masks the CSR write.
    assign accept    = in_valid && in_ready;
    assign do_ebreak = accept && in_ebreak;
    assign do_ecall  = accept && !in_ebreak && in_ecall;
    assign do_mret   = accept && !in_ebreak && !in_ecall && in_mret;
    assign csr_wen   = accept && in_csr_wen
                     && !(in_ebreak || in_ecall || in_mret);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            S_RUN: begin
                in_ready = 1'b1;
                if (do_ebreak) begin
                    state_d = S_HALT;
                end else if (do_ecall || do_mret) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen         <= 1'b0;
            rf_waddr       <= 5'd0;
            rf_wdata       <= 32'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush          <= 1'b0;
            halt           <= 1'b0;
            retire_valid   <= 1'b0;
            retire_pc      <= 32'd0;
        end else begin
            rf_wen         <= accept && in_reg_wen && !in_ebreak;
            redirect_valid <= do_ecall || do_mret;
            flush          <= do_ecall || do_mret;
            retire_valid   <= accept;
            halt           <= halt || do_ebreak;
            if (accept) begin
                rf_waddr  <= in_rd;
                rf_wdata  <= in_result;
                retire_pc <= in_pc;
            end
            if (do_ecall) begin
                redirect_pc <= mtvec;
            end else if (do_mret) begin
                redirect_pc <= mepc;
            end
        end
    end

    wbu_csr_file #(
        .RESET_MSTATUS (RESET_MSTATUS),
        .RESET_MTVEC   (RESET_MTVEC),
        .ECALL_CAUSE   (ECALL_CAUSE)
    ) u_csr (
        .clk     (clk),
        .rst     (rst),
        .wen     (csr_wen),
        .waddr   (in_csr_addr),
        .wdata   (in_csr_wdata),
        .trap    (do_ecall),
        .trap_pc (in_pc),
        .retire  (retire_valid),
        .raddr   (csr_raddr),
        .rdata   (csr_rdata),
        .mtvec   (mtvec),
        .mepc    (mepc)
    );

endmodule

// File: tb/tb_wbu_pipeline.sv
// Directed test for wbu_pipeline: retire, CSR writes, ecall/mret, ebreak
// halt, dropped CSR writes, back-to-back accepts, optional minstret.
module tb_wbu_pipeline;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_reg_wen;
    logic        in_csr_wen;
    logic [11:0] in_csr_addr;
    logic [31:0] in_csr_wdata;
    logic        in_ebreak;
    logic        in_ecall;
    logic        in_mret;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        halt;
    logic        retire_valid;
    logic [31:0] retire_pc;

    int checks = 0;
    int errors = 0;

    wbu_pipeline dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_result      (in_result),
        .in_rd          (in_rd),
        .in_reg_wen     (in_reg_wen),
        .in_csr_wen     (in_csr_wen),
        .in_csr_addr    (in_csr_addr),
        .in_csr_wdata   (in_csr_wdata),
        .in_ebreak      (in_ebreak),
        .in_ecall       (in_ecall),
        .in_mret        (in_mret),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .halt           (halt),
        .retire_valid   (retire_valid),
        .retire_pc      (retire_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_bundle();
        in_valid     = 1'b0;
        in_pc        = 32'd0;
        in_inst      = 32'h0000_0013;
        in_result    = 32'd0;
        in_rd        = 5'd0;
        in_reg_wen   = 1'b0;
        in_csr_wen   = 1'b0;
        in_csr_addr  = 12'd0;
        in_csr_wdata = 32'd0;
        in_ebreak    = 1'b0;
        in_ecall     = 1'b0;
        in_mret      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_bundle();
        csr_raddr = 12'h300;
        tick();
        tick();
        checks++;
        if (rf_wen !== 1'b0 || retire_valid !== 1'b0 || halt !== 1'b0
            || flush !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: rf_wen=%b retire=%b halt=%b flush=%b redir=%b want all 0",
                     rf_wen, retire_valid, halt, flush, redirect_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        checks++;
        if (csr_rdata !== 32'h0000_1800) begin
            errors++;
            $display("FAIL reset_mstatus: got %h want 00001800", csr_rdata);
        end
        csr_raddr = 12'h305;
        #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mtvec: got %h want 00000000", csr_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rf_write();
        clear_bundle();
        in_valid   = 1'b1;
        in_pc      = 32'h8000_0000;
        in_rd      = 5'd5;
        in_reg_wen = 1'b1;
        in_result  = 32'hDEAD_BEEF;
        tick();
        clear_bundle();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rf_write: wen=%b addr=%0d data=%h want 1/5/deadbeef",
                     rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (retire_valid !== 1'b1 || retire_pc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL rf_retire: valid=%b pc=%h want 1/80000000",
                     retire_valid, retire_pc);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL rf_pulse: wen=%b retire=%b want 0/0", rf_wen, retire_valid);
        end
    endtask

    task automatic test_ecall();
        clear_bundle();
        in_valid     = 1'b1;
        in_pc        = 32'h8000_000C;
        in_csr_wen   = 1'b1;
        in_csr_addr  = 12'h305;
        in_csr_wdata = 32'h8000_0100;
        tick();
        clear_bundle();
        csr_raddr = 12'h305;
        #1;
        checks++;
        if (csr_rdata !== 32'h8000_0100) begin
            errors++;
            $display("FAIL ecall_mtvec_rd: got %h want 80000100", csr_rdata);
        end
        in_valid = 1'b1;
        in_pc    = 32'h8000_0010;
        in_ecall = 1'b1;
        tick();
        clear_bundle();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0100
            || flush !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ecall_redirect: rv=%b pc=%h flush=%b ready=%b want 1/80000100/1/0",
                     redirect_valid, redirect_pc, flush, in_ready);
        end
        tick();
        checks++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ecall_flush_end: flush=%b rv=%b ready=%b want 0/0/1",
                     flush, redirect_valid, in_ready);
        end
        csr_raddr = 12'h341;
        #1;
        checks++;
        if (csr_rdata !== 32'h8000_0010) begin
            errors++;
            $display("FAIL ecall_mepc: got %h want 80000010", csr_rdata);
        end
        csr_raddr = 12'h342;
        #1;
        checks++;
        if (csr_rdata !== 32'd11) begin
            errors++;
            $display("FAIL ecall_mcause: got %0d want 11", csr_rdata);
        end
    endtask

    task automatic test_mret();
        clear_bundle();
        in_valid = 1'b1;
        in_pc    = 32'h8000_0100;
        in_mret  = 1'b1;
        tick();
        clear_bundle();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0010
            || flush !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mret_redirect: rv=%b pc=%h flush=%b ready=%b want 1/80000010/1/0",
                     redirect_valid, redirect_pc, flush, in_ready);
        end
        tick();
        checks++;
        if (flush !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mret_flush_end: flush=%b ready=%b want 0/1", flush, in_ready);
        end
        csr_raddr = 12'h342;
        #1;
        checks++;
        if (csr_rdata !== 32'd11) begin
            errors++;
            $display("FAIL mret_mcause: got %0d want 11", csr_rdata);
        end
    endtask

    task automatic test_precedence();
        clear_bundle();
        in_valid     = 1'b1;
        in_pc        = 32'h8000_0200;
        in_ecall     = 1'b1;
        in_mret      = 1'b1;
        in_csr_wen   = 1'b1;
        in_csr_addr  = 12'h305;
        in_csr_wdata = 32'h1111_2222;
        tick();
        clear_bundle();
        checks++;
        if (redirect_pc !== 32'h8000_0100 || flush !== 1'b1) begin
            errors++;
            $display("FAIL prec_ecall: pc=%h flush=%b want 80000100/1", redirect_pc, flush);
        end
        tick();
        csr_raddr = 12'h305;
        #1;
        checks++;
        if (csr_rdata !== 32'h8000_0100) begin
            errors++;
            $display("FAIL prec_csr_masked: got %h want 80000100", csr_rdata);
        end
    endtask

    task automatic test_ebreak();
        clear_bundle();
        in_valid     = 1'b1;
        in_pc        = 32'h8000_0300;
        in_ebreak    = 1'b1;
        in_reg_wen   = 1'b1;
        in_rd        = 5'd3;
        in_result    = 32'h5555_AAAA;
        in_csr_wen   = 1'b1;
        in_csr_addr  = 12'h300;
        in_csr_wdata = 32'hFFFF_FFFF;
        tick();
        clear_bundle();
        checks++;
        if (halt !== 1'b1 || rf_wen !== 1'b0 || retire_valid !== 1'b1
            || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_halt: halt=%b rf_wen=%b retire=%b ready=%b want 1/0/1/0",
                     halt, rf_wen, retire_valid, in_ready);
        end
        in_valid = 1'b1;
        in_pc    = 32'h8000_0304;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (halt !== 1'b1 || in_ready !== 1'b0 || retire_valid !== 1'b0) begin
                errors++;
                $display("FAIL ebreak_sticky[%0d]: halt=%b ready=%b retire=%b want 1/0/0",
                         i, halt, in_ready, retire_valid);
            end
        end
        clear_bundle();
        csr_raddr = 12'h300;
        #1;
        checks++;
        if (csr_rdata !== 32'h0000_1800) begin
            errors++;
            $display("FAIL ebreak_csr_masked: got %h want 00001800", csr_rdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (halt !== 1'b0 || in_ready !== 1'b1 || retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_async_rst: halt=%b ready=%b retire=%b want 0/1/0",
                     halt, in_ready, retire_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bad_csr();
        logic [11:0] addrs [5];
        logic [31:0] want  [5];
        addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
        want  = '{32'h0000_1800, 32'h0, 32'h0, 32'h0, 32'h0};
        clear_bundle();
        in_valid     = 1'b1;
        in_pc        = 32'h8000_0400;
        in_csr_wen   = 1'b1;
        in_csr_addr  = 12'h7C0;
        in_csr_wdata = 32'h0000_1234;
        tick();
        clear_bundle();
        for (int i = 0; i < 5; i++) begin
            csr_raddr = addrs[i];
            #1;
            checks++;
            if (csr_rdata !== want[i]) begin
                errors++;
                $display("FAIL bad_csr[%h]: got %h want %h", addrs[i], csr_rdata, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        clear_bundle();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h0000_0100 + 32'(i * 4);
            tick();
            checks++;
            if (retire_valid !== 1'b1 || retire_pc !== 32'h0000_0100 + 32'(i * 4)) begin
                errors++;
                $display("FAIL b2b_retire[%0d]: valid=%b pc=%h want 1/%h",
                         i, retire_valid, retire_pc, 32'h0000_0100 + 32'(i * 4));
            end
            if (retire_valid === 1'b1) pulses++;
        end
        clear_bundle();
        tick();
        if (retire_valid === 1'b1) pulses++;
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 4", pulses);
        end
    endtask

`ifdef WBU_INSTRET_EN
    task automatic test_instret();
        clear_bundle();
        tick();
        force dut.u_csr.minstret = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.u_csr.minstret;
        in_valid     = 1'b1;
        in_pc        = 32'h8000_0500;
        in_csr_wen   = 1'b1;
        in_csr_addr  = 12'hB82;
        in_csr_wdata = 32'h7777_7777;
        tick();
        clear_bundle();
        tick();
        csr_raddr = 12'hB02;
        #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL instret_lo: got %h want 00000000", csr_rdata);
        end
        csr_raddr = 12'hB82;
        #1;
        checks++;
        if (csr_rdata !== 32'h1) begin
            errors++;
            $display("FAIL instret_hi: got %h want 00000001", csr_rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rf_write();
        test_ecall();
        test_mret();
        test_precedence();
        test_ebreak();
        test_bad_csr();
        test_back_to_back();
`ifdef WBU_INSTRET_EN
        test_instret();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
